// File: rtl/alu_16.sv
// alu_16: 16-bit ALU with combinational z/v/n flags and a loadable flag register.
// Define ALU_ROT_EN to turn opcodes 110/111 into rotates instead of zero-fill shifts.
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`define ALU_SUB 3'b001
`define ALU_INC 3'b010
`define ALU_AND 3'b011
`define ALU_OR  3'b100
`define ALU_XOR 3'b101
`define ALU_SHL 3'b110
`define ALU_SHR 3'b111
`endif

module alu_16 (
    input  logic [2:0]  alu_op,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    output logic [15:0] alu_out,
    output logic        z,
    output logic        v,
    output logic        n,
    input  logic        clk,
    input  logic        rst,
    input  logic        flag_we,
    output logic        z_q,
    output logic        v_q,
    output logic        n_q
);
    logic [3:0]  sh;
    logic [15:0] sum, diff, shl, shr;
    assign sh   = alu_b[3:0];
    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;
`ifdef ALU_ROT_EN
    assign shl = (alu_a << sh) | (alu_a >> (5'd16 - {1'b0, sh}));
    assign shr = (alu_a >> sh) | (alu_a << (5'd16 - {1'b0, sh}));
`else
    assign shl = alu_a << sh;
    assign shr = alu_a >> sh;
`endif
    always_comb begin
        alu_out = sum;
        v       = 1'b0;
        case (alu_op)
            `ALU_ADD, `ALU_INC: begin
                alu_out = sum;
                v       = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
            end
            `ALU_SUB: begin
                alu_out = diff;
                v       = (alu_a[15] != alu_b[15]) && (diff[15] != alu_a[15]);
            end
            `ALU_AND: alu_out = alu_a & alu_b;
            `ALU_OR:  alu_out = alu_a | alu_b;
            `ALU_XOR: alu_out = alu_a ^ alu_b;
            `ALU_SHL: alu_out = shl;
            default:  alu_out = shr;
        endcase
    end
    assign z = alu_out == 16'h0000;
    assign n = alu_out[15];
    always_ff @(posedge clk) begin
        if (rst) {z_q, v_q, n_q} <= 3'b000;
        else if (flag_we) {z_q, v_q, n_q} <= {z, v, n};
    end
endmodule

// File: tb/tb_alu_16.sv
// tb_alu_16: randomized check of alu_16 against an arithmetic reference model.
module tb_alu_16;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        z, v, n, clk, rst, flag_we, z_q, v_q, n_q;
    int          n_tests, n_fail;
    logic [2:0]  fq;

    alu_16 dut (
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .z(z), .v(v), .n(n), .clk(clk), .rst(rst), .flag_we(flag_we),
        .z_q(z_q), .v_q(v_q), .n_q(n_q)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns {out, z, v, n}
    function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r, k;
        logic [15:0] o;
        logic ov;
        sa = $signed(a);
        sb = $signed(b);
        k  = int'(b[3:0]);
        ov = 1'b0;
        r  = 0;
        o  = 16'h0;
        case (op)
            3'd0, 3'd2: begin r = sa + sb; o = 16'(r); ov = (r > 32767) || (r < -32768); end
            3'd1:       begin r = sa - sb; o = 16'(r); ov = (r > 32767) || (r < -32768); end
            3'd3: o = a & b;
            3'd4: o = a | b;
            3'd5: o = a ^ b;
`ifdef ALU_ROT_EN
            3'd6: begin o = a; for (int i = 0; i < k; i++) o = {o[14:0], o[15]}; end
            default: begin o = a; for (int i = 0; i < k; i++) o = {o[0], o[15:1]}; end
`else
            3'd6: o = 16'((int'(a) * (1 << k)) % 65536);
            default: o = 16'(int'(a) / (1 << k));
`endif
        endcase
        return {o, o == 16'h0, ov, o[15]};
    endfunction

    task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic r, input logic we);
        logic [18:0] e;
        alu_op = op; alu_a = a; alu_b = b; rst = r; flag_we = we;
        #1;
        e = model(op, a, b);
        check($sformatf("comb op=%0d a=%h b=%h", op, a, b), {alu_out, z, v, n}, e);
        @(posedge clk);
        fq = r ? 3'b000 : (we ? e[2:0] : fq);
        #1;
        check($sformatf("flags rst=%0b we=%0b", r, we), {16'h0, z_q, v_q, n_q}, {16'h0, fq});
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [18:0] exp);
        alu_op = op; alu_a = a; alu_b = b;
        #1;
        check(tag, {alu_out, z, v, n}, exp);
    endtask

    initial begin
        logic [15:0] ra, rb;
        n_tests = 0; n_fail = 0; fq = 3'b000;
        alu_op = 3'd0; alu_a = 16'h0; alu_b = 16'h0; rst = 1; flag_we = 0;
        @(posedge clk);
        #1;
        check("reset flags", {16'h0, z_q, v_q, n_q}, 19'h0);
        directed("inc 1+1",      3'd2, 16'h0001, 16'h0001, {16'h0002, 3'b000});
        directed("inc 7fff+1",   3'd2, 16'h7FFF, 16'h0001, {16'h8000, 3'b011});
        directed("inc ffff+ffff",3'd2, 16'hFFFF, 16'hFFFF, {16'hFFFE, 3'b001});
        directed("inc ffff+1",   3'd2, 16'hFFFF, 16'h0001, {16'h0000, 3'b100});
        directed("sub 8000-1",   3'd1, 16'h8000, 16'h0001, {16'h7FFF, 3'b010});
        directed("and",          3'd3, 16'hF0F0, 16'h0FF0, {16'h00F0, 3'b000});
        directed("xor zero",     3'd5, 16'hA5A5, 16'hA5A5, {16'h0000, 3'b100});
`ifdef ALU_ROT_EN
        directed("rol 4",        3'd6, 16'h8001, 16'h0004, {16'h0018, 3'b000});
        directed("ror 1",        3'd7, 16'h0001, 16'h0011, {16'h8000, 3'b001});
`else
        directed("shl 4",        3'd6, 16'h8001, 16'h0004, {16'h0010, 3'b000});
        directed("shr 1",        3'd7, 16'h8001, 16'h0011, {16'h4000, 3'b000});
`endif
        step(3'd2, 16'h7FFF, 16'h0001, 1'b1, 1'b1);
        check("rst overrides we", {16'h0, z_q, v_q, n_q}, 19'h0);
        step(3'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        check("load 0/1/1", {16'h0, z_q, v_q, n_q}, {16'h0, 3'b011});
        step(3'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("hold", {16'h0, z_q, v_q, n_q}, {16'h0, 3'b011});
        for (int i = 0; i < 500; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'h7FFF << $urandom_range(0, 1) : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            step(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 15) == 0, 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_16.md
ALU_16 -- requirements
Module: alu_16

Interface
REQ-001 The module SHALL have a clk input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have an rst input, 1 bit, synchronous active-high reset for the flag register.
REQ-003 The module SHALL have an alu_op input, 3 bits, operation select; encodings come from the shared macros ALU_ADD, ALU_SUB, ALU_INC, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR.
REQ-004 The module SHALL have an alu_a input, 16 bits, first operand, two's complement.
REQ-005 The module SHALL have an alu_b input, 16 bits, second operand, two's complement.
REQ-006 The module SHALL have an alu_out output, 16 bits, combinational result.
REQ-007 The module SHALL have a z output, 1 bit, combinational zero flag.
REQ-008 The module SHALL have a v output, 1 bit, combinational signed-overflow flag.
REQ-009 The module SHALL have an n output, 1 bit, combinational sign flag.
REQ-010 The module SHALL have a flag_we input, 1 bit, flag register load enable.
REQ-011 The module SHALL have z_q, v_q and n_q outputs, 1 bit each, registered copies of z, v and n.
REQ-012 Port declaration order SHALL be alu_op, alu_a, alu_b, alu_out, z, v, n, clk, rst, flag_we, z_q, v_q, n_q, so that seven-port positional instantiation connects correctly.

Function
REQ-013 Opcode encodings SHALL be: ADD 000, SUB 001, INC 010, AND 011, OR 100, XOR 101, SHL 110, SHR 111.
REQ-014 ADD and INC SHALL both produce alu_a + alu_b, truncated to 16 bits; for INC, alu_b carries the increment amount.
REQ-015 SUB SHALL produce alu_a - alu_b, truncated to 16 bits.
REQ-016 AND, OR and XOR SHALL be bitwise operations of alu_a and alu_b.
REQ-017 SHL SHALL produce alu_a << alu_b[3:0], zero fill.
REQ-018 SHR SHALL produce a logical alu_a >> alu_b[3:0], zero fill.
REQ-019 n SHALL equal alu_out[15] for every opcode.
REQ-020 z SHALL be 1 exactly when alu_out == 16'h0000, for every opcode.
REQ-021 For ADD and INC, v SHALL be 1 when alu_a[15] == alu_b[15] and alu_out[15] != alu_a[15].
REQ-022 For SUB, v SHALL be 1 when alu_a[15] != alu_b[15] and alu_out[15] != alu_a[15].
REQ-023 For logic and shift opcodes, v SHALL be 0.
REQ-024 alu_out, z, v and n SHALL be purely combinational, with no clock dependency and zero-cycle latency, and SHALL settle within the same delta time as an input change.
REQ-025 On a rising clk edge with rst low and flag_we high, the flag register SHALL load z_q/v_q/n_q from z/v/n, which become visible one cycle later.
REQ-026 With flag_we low, the flag register SHALL hold its values.

Reset
REQ-027 On a rising clk edge with rst high, z_q, v_q and n_q SHALL be cleared to 0, overriding flag_we.
REQ-028 rst SHALL NOT affect the combinational outputs.

Configuration
REQ-029 When ALU_ROT_EN is defined, opcode 110 SHALL rotate alu_a left and opcode 111 SHALL rotate alu_a right, each by alu_b[3:0], with v=0.
REQ-030 When ALU_ROT_EN is undefined, opcodes 110 and 111 SHALL behave as the zero-fill shifts of REQ-017 and REQ-018.

Verification
REQ-031 INC, a=0x0001, b=0x0001 -> out=0x0002, z=0, v=0, n=0.
REQ-032 INC, a=0x7FFF, b=0x0001 -> out=0x8000, n=1, z=0, v=1.
REQ-033 INC, a=0xFFFF, b=0xFFFF -> out=0xFFFE, n=1, z=0, v=0.
REQ-034 INC, a=0xFFFF, b=0x0001 -> out=0x0000, z=1, n=0, v=0.
REQ-035 SUB, a=0x8000, b=0x0001 -> out=0x7FFF, v=1, n=0, z=0.
REQ-036 With rst=1 for one edge, then flag_we=1 while out=0x8000 with v=1 -> z_q/v_q/n_q read 0/0/0 after the reset edge and 0/1/1 after the load edge.
